// File: rtl/adam_pkg.sv
// Shared types and elaboration helpers for the adam reset sequencer family.
package adam_pkg;

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_STAGGER,
        ST_RUN,
        ST_PAUSE,
        ST_SRST
    } adam_rst_seq_state_t;

    // Wide enough for the longer of the hold and stagger intervals.
    function automatic int adam_cnt_width(input int hold_cycles, input int stagger_cycles);
        return $clog2(((hold_cycles > stagger_cycles) ? hold_cycles : stagger_cycles) + 1);
    endfunction

    function automatic int adam_idx_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/adam_rst_seq_if.sv
// Per-channel reset / quiesce handshake between the sequencer and its clients.
interface adam_rst_seq_if #(
    parameter int NO_CHANNELS = 3
);
    logic [NO_CHANNELS-1:0] srst_req;
    logic [NO_CHANNELS-1:0] pause_req;
    logic [NO_CHANNELS-1:0] pause_ack;
    logic [NO_CHANNELS-1:0] rst_out;

    modport master (
        input  srst_req,
        input  pause_ack,
        output pause_req,
        output rst_out
    );

    modport slave (
        output srst_req,
        output pause_ack,
        input  pause_req,
        input  rst_out
    );
endinterface

// File: rtl/adam_debounce.sv
// Two-flop synchroniser for the active-low board reset, followed by a stability
// filter when ADAM_RST_SEQ_DEBOUNCE_EN is defined.
module adam_debounce #(
    parameter int CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic async_n,
    output logic level
);
    logic sync_1;
    logic sync_2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= async_n;
            sync_2 <= sync_1;
        end
    end

`ifdef ADAM_RST_SEQ_DEBOUNCE_EN
    localparam logic [7:0] LAST = 8'(CYCLES - 1);

    logic [7:0] run_cnt;
    logic       stable;

    // A new level is taken only after CYCLES consecutive samples that differ from
    // the accepted one; any agreeing sample restarts the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt <= '0;
            stable  <= 1'b1;
        end else if (sync_2 == stable) begin
            run_cnt <= '0;
        end else if (run_cnt == LAST) begin
            run_cnt <= '0;
            stable  <= sync_2;
        end else begin
            run_cnt <= run_cnt + 8'd1;
        end
    end

    assign level = stable;
`else
    logic unused_cycles;

    assign unused_cycles = ^(8'(CYCLES));
    assign level         = sync_2;
`endif

endmodule

// File: rtl/adam_rst_seq.sv
// Staggered power-on reset release plus per-channel quiesce-then-reset sequencing.
// Build option: define ADAM_RST_SEQ_DEBOUNCE_EN to filter ext_rst_n.
module adam_rst_seq #(
    parameter int NO_CHANNELS     = 3,
    parameter int HOLD_CYCLES     = 16,
    parameter int STAGGER_CYCLES  = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ext_rst_n,
    output logic           busy,
    adam_rst_seq_if.master bus
);
    import adam_pkg::*;

    localparam int               CNT_W     = adam_cnt_width(HOLD_CYCLES, STAGGER_CYCLES);
    localparam int               CH_W      = adam_idx_width(NO_CHANNELS);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'((STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0);
    localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NO_CHANNELS - 1);
    localparam bit               ONE_SHOT  = (STAGGER_CYCLES == 0) || (NO_CHANNELS == 1);

    adam_rst_seq_state_t    state;
    adam_rst_seq_state_t    state_d;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_d;
    logic [CNT_W-1:0]       cnt_inc;
    logic [CH_W-1:0]        chan;
    logic [CH_W-1:0]        chan_d;
    logic [CH_W-1:0]        low_req;
    logic [NO_CHANNELS-1:0] rst_out_q;
    logic [NO_CHANNELS-1:0] rst_out_d;
    logic [NO_CHANNELS-1:0] pause_q;
    logic [NO_CHANNELS-1:0] pause_d;
    logic                   ext_level;

    adam_debounce #(
        .CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .async_n(ext_rst_n),
        .level  (ext_level)
    );

    assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    // Lowest-index software request wins.
    always_comb begin
        low_req = '0;
        for (int k = NO_CHANNELS - 1; k >= 0; k--) begin
            if (bus.srst_req[k]) low_req = CH_W'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_HOLD;
            cnt       <= '0;
            chan      <= '0;
            rst_out_q <= '1;
            pause_q   <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            chan      <= chan_d;
            rst_out_q <= rst_out_d;
            pause_q   <= pause_d;
        end
    end

    // During STAGGER, chan is the next channel to be released; elsewhere it is the
    // channel owning the current software reset.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        chan_d  = chan;
        if (!ext_level) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            chan_d  = '0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt_d = '0;
                        if (ONE_SHOT) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_STAGGER;
                            chan_d  = CH_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_STAGGER: begin
                    if (cnt == STAG_LAST) begin
                        cnt_d = '0;
                        if (chan == LAST_CH) begin
                            state_d = ST_RUN;
                            chan_d  = '0;
                        end else begin
                            chan_d = chan + CH_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_RUN: begin
                    if (|bus.srst_req) begin
                        state_d = ST_PAUSE;
                        chan_d  = low_req;
                    end
                end
                ST_PAUSE: begin
                    if (bus.pause_ack[chan]) begin
                        state_d = ST_SRST;
                        cnt_d   = '0;
                    end
                end
                ST_SRST: begin
                    if (cnt == HOLD_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    chan_d  = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they never glitch.
    always_comb begin
        rst_out_d = '0;
        pause_d   = '0;
        case (state_d)
            ST_HOLD: rst_out_d = '1;
            ST_STAGGER: begin
                for (int k = 0; k < NO_CHANNELS; k++) begin
                    rst_out_d[k] = (k >= int'(chan_d));
                end
            end
            ST_PAUSE: pause_d[chan_d] = 1'b1;
            ST_SRST: begin
                rst_out_d[chan_d] = 1'b1;
                pause_d[chan_d]   = 1'b1;
            end
            default: begin
                rst_out_d = '0;
                pause_d   = '0;
            end
        endcase
    end

    assign bus.rst_out   = rst_out_q;
    assign bus.pause_req = pause_q;
    assign busy          = (state != ST_RUN);

endmodule
